// File: rtl/collide_ctrl_pkg.sv
// Shared types and default parameters for the dCollideSpheres sequencer.
//   state_t      - controller FSM states
//   DEF_*        - default parameter values used by collide_seq_ctrl
//   is_run_state - true for the states that a host_run drop aborts
package collide_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE, LOAD, CRST, WAIT_BUSY, WAIT_DONE, CAPTURE, WRITE, FINISH
  } state_t;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_CH   = 8;
  localparam int DEF_N_REC    = 4;
  localparam int DEF_IN_DEPTH = 16;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_WE_CYC   = 3;
  localparam int DEF_RST_CYC  = 1;

  function automatic logic is_run_state(state_t s);
    return s inside {CRST, WAIT_BUSY, WAIT_DONE, CAPTURE, WRITE};
  endfunction

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: registers the previous input sample.
//   clk, rst_n - clock, async active-low reset (previous sample clears to 0)
//   d          - level input
//   rise       - high in the first cycle d is seen high after being low
module edge_rise_det (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= d;
  end

  assign rise = d & ~prev;

endmodule

// File: rtl/collide_seq_ctrl.sv
// Sequencer between the host-loaded input memory, the dCollideSpheres core
// and the result memory.
//   clk, rstmaster           - clock, async active-low reset
//   host_run, host_rdy       - phase select (0 load / 1 run), load request
//   core_done, core_fetch    - core idle flag, record fetch request
//   res_in / res_out         - core result vector in / registered copy out
//   core_rst_n, oe           - core reset pulse, input-memory read enable
//   in_addr, in_we           - input-memory write port (load phase)
//   rd_addr                  - input-memory read address for the core
//   out_addr, out_we         - result-memory write port
//   load_full, busy, done_all - status
// All outputs are flops; control outputs are loaded from the next state so
// they line up exactly with the state they describe.
module collide_seq_ctrl
  import collide_ctrl_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int N_REC    = DEF_N_REC,
  parameter int IN_DEPTH = DEF_IN_DEPTH,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int WE_CYC   = DEF_WE_CYC,
  parameter int RST_CYC  = DEF_RST_CYC
) (
  input  logic                     clk,
  input  logic                     rstmaster,
  input  logic                     host_run,
  input  logic                     host_rdy,
  input  logic                     core_done,
  input  logic                     core_fetch,
  input  logic [NUM_CH*DATA_W-1:0] res_in,
  output logic                     core_rst_n,
  output logic                     oe,
  output logic [ADDR_W-1:0]        in_addr,
  output logic                     in_we,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [ADDR_W-1:0]        out_addr,
  output logic                     out_we,
  output logic [NUM_CH*DATA_W-1:0] res_out,
  output logic                     load_full,
  output logic                     busy,
  output logic                     done_all
);

  localparam int CNT_MAX = (WE_CYC > RST_CYC) ? WE_CYC : RST_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int REC_W   = $clog2(N_REC + 1);

  localparam logic [CNT_W-1:0]  WE_LAST  = CNT_W'(WE_CYC - 1);
  localparam logic [CNT_W-1:0]  RST_LAST = CNT_W'(RST_CYC - 1);
  localparam logic [REC_W-1:0]  REC_LAST = REC_W'(N_REC - 1);
  localparam logic [ADDR_W-1:0] STRIDE   = ADDR_W'(NUM_CH);
  localparam logic [ADDR_W-1:0] RD_MAX   = ADDR_W'((N_REC - 1) * NUM_CH);
  localparam logic [ADDR_W-1:0] DEPTH    = ADDR_W'(IN_DEPTH);

  state_t             state, nxt;
  logic [CNT_W-1:0]   cnt;
  logic [REC_W-1:0]   rec;
  logic               rdy_rise, fetch_rise, abort, fetch_ok;
  logic [ADDR_W-1:0]  in_addr_nxt;

  edge_rise_det u_rdy_edge   (.clk(clk), .rst_n(rstmaster), .d(host_rdy),   .rise(rdy_rise));
  edge_rise_det u_fetch_edge (.clk(clk), .rst_n(rstmaster), .d(core_fetch), .rise(fetch_rise));

  // host_run low in a run state abandons the run; all datapath updates of
  // that cycle are suppressed so addresses and res_out hold.
  assign abort       = !host_run && is_run_state(state);
  assign fetch_ok    = fetch_rise && !abort && rd_addr < RD_MAX &&
                       (state inside {WAIT_BUSY, WAIT_DONE, CAPTURE, WRITE});
  assign in_addr_nxt = in_addr + 1'b1;

  always_comb begin
    nxt = state;
    if (abort) nxt = IDLE;
    else begin
      case (state)
        IDLE: begin
          if (!host_run && core_done && rdy_rise && !load_full) nxt = LOAD;
          else if (host_run && core_done)                       nxt = CRST;
        end
        LOAD:      if (cnt == WE_LAST)  nxt = IDLE;
        CRST:      if (cnt == RST_LAST) nxt = WAIT_BUSY;
        WAIT_BUSY: if (!core_done)      nxt = WAIT_DONE;
        WAIT_DONE: if (core_done)       nxt = CAPTURE;
        CAPTURE:                        nxt = WRITE;
        WRITE:     nxt = (rec == REC_LAST) ? FINISH : WAIT_BUSY;
        FINISH:    if (!host_run)       nxt = IDLE;
        default:                        nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstmaster) begin
    if (!rstmaster) begin
      state      <= IDLE;
      cnt        <= '0;
      rec        <= '0;
      core_rst_n <= 1'b1;
      oe         <= 1'b0;
      in_we      <= 1'b0;
      out_we     <= 1'b0;
      busy       <= 1'b0;
      done_all   <= 1'b0;
      load_full  <= 1'b0;
      in_addr    <= '0;
      rd_addr    <= '0;
      out_addr   <= '0;
      res_out    <= '0;
    end else begin
      state      <= nxt;
      // dwell counter for the multi-cycle LOAD and CRST states
      cnt        <= (nxt == state && (state == LOAD || state == CRST)) ? cnt + 1'b1 : '0;
      core_rst_n <= (nxt != CRST);
      oe         <= (nxt inside {CRST, WAIT_BUSY, WAIT_DONE, CAPTURE, WRITE, FINISH});
      in_we      <= (nxt == LOAD);
      out_we     <= (nxt == WRITE);
      busy       <= !(nxt inside {IDLE, FINISH});
      done_all   <= (nxt == FINISH);

      if (state == LOAD && cnt == WE_LAST) begin
        in_addr   <= in_addr_nxt;
        load_full <= (in_addr_nxt == DEPTH);
      end

      if (state == CRST && !abort) begin
        rd_addr  <= '0;
        out_addr <= '0;
        rec      <= '0;
      end else if (fetch_ok) begin
        rd_addr <= rd_addr + STRIDE;
      end

      if (state == CAPTURE && !abort) res_out <= res_in;

      if (state == WRITE && !abort) begin
        out_addr <= out_addr + STRIDE;
        rec      <= rec + 1'b1;
      end
    end
  end

endmodule

// File: doc/collide_seq_ctrl.md
Name: collide_seq_ctrl

Overview:
- Parametrised sequencer between host-loaded input memory, the dCollideSpheres pipeline core and the result memory.
- Load phase: writes host words into input memory; each word is acknowledged by a ready handshake.
- Run phase: resets the core, streams record read addresses on core fetch requests, captures each NUM_CH-wide result vector, writes it to output memory, and flags completion after N_REC results.
- Generalises the fixed 8-channel/12-word controller: channel count, record count, write-enable width and core-reset width are parameters; adds abort, saturation and completion status.

Parameters:
- DATA_W, 32, width of one result channel.
- NUM_CH, 8, result channels per record; also the read-address stride per fetch.
- N_REC, 4, number of result records to collect per run.
- IN_DEPTH, 16, input-memory words available to the load phase.
- ADDR_W, 16, width of all address outputs.
- WE_CYC, 3, cycles in_we stays high per loaded word (at least 1).
- RST_CYC, 1, cycles core_rst_n stays low at run start (at least 1).

Ports:
- clk  in  1  system clock.
- rstmaster  in  1  asynchronous active-low reset.
- host_run  in  1  0 = load phase, 1 = run phase.
- host_rdy  in  1  host word valid; the rising edge is the load request.
- core_done  in  1  core idle/finished.
- core_fetch  in  1  core requests the next record; the rising edge is the request.
- res_in  in  NUM_CH*DATA_W  core result vector, channel 0 in the LSBs.
- core_rst_n  out  1  active-low core reset pulse.
- oe  out  1  input-memory read enable, high throughout the run phase.
- in_addr  out  ADDR_W  input-memory write address.
- in_we  out  1  input-memory write enable.
- rd_addr  out  ADDR_W  input-memory read address for the core.
- out_addr  out  ADDR_W  result-memory base address of the current record.
- out_we  out  1  result-memory write enable.
- res_out  out  NUM_CH*DATA_W  registered result vector.
- load_full  out  1  in_addr has reached IN_DEPTH.
- busy  out  1  FSM is not in IDLE or FINISH.
- done_all  out  1  N_REC records have been written.

Behaviour:
- Reset values (asynchronous, all outputs registered):
  - core_rst_n=1.
  - oe, in_we, out_we, load_full, busy, done_all = 0.
  - All addresses = 0; res_out = 0; state = IDLE; edge-detect registers = 0.
- FSM states:
  - IDLE:
    - host_run=0, core_done=1 and a host_rdy rising edge -> LOAD, unless load_full (request ignored).
    - host_run=1 and core_done=1 -> CRST.
  - LOAD:
    - in_we=1 for exactly WE_CYC cycles.
    - On the last cycle, in_addr increments by 1; load_full sets when in_addr reaches IN_DEPTH.
    - Then -> IDLE. A new host_rdy edge during LOAD is dropped.
  - CRST:
    - core_rst_n=0 for RST_CYC cycles.
    - rd_addr and out_addr clear to 0; the record counter clears.
    - Then -> WAIT_BUSY.
  - WAIT_BUSY: core_done=0 -> WAIT_DONE.
  - WAIT_DONE: core_done=1 -> CAPTURE.
  - CAPTURE: res_out <= res_in (single cycle) -> WRITE.
  - WRITE:
    - out_we=1 for exactly one cycle at the current out_addr.
    - Next cycle: out_addr += NUM_CH and the record counter increments.
    - Counter reaches N_REC -> FINISH; otherwise -> WAIT_BUSY.
  - FINISH: done_all=1 and held; host_run=0 -> IDLE, done_all clears.
- oe=1 in CRST through FINISH, 0 otherwise.
- Fetch handling:
  - In WAIT_BUSY, WAIT_DONE, CAPTURE and WRITE, each core_fetch rising edge advances rd_addr by NUM_CH.
  - rd_addr saturates at (N_REC-1)*NUM_CH; excess requests are ignored.
  - Fetch edges in other states are discarded.
- Simultaneous events: a fetch edge in the same cycle as CAPTURE or WRITE — both actions take effect.
- Abort: host_run falling in any run-phase state -> IDLE next cycle.
  - out_we and core_rst_n return to their inactive values.
  - rd_addr and out_addr are held; res_out is held.
  - in_addr and load_full are untouched by the run phase.
- Load pointer: in_addr never wraps; it clears only on rstmaster.
- Address arithmetic: unsigned, ADDR_W bits; parameters must satisfy N_REC*NUM_CH < 2**ADDR_W.

Decomposition:
- Package collide_ctrl_pkg: state enum (IDLE, LOAD, CRST, WAIT_BUSY, WAIT_DONE, CAPTURE, WRITE, FINISH) and the default parameter constants.
- One sub-module, edge_rise_det (registered, asynchronous active-low reset), instantiated for host_rdy and core_fetch.

Test Plan:
- Reset mid-LOAD (in_we=1, in_addr=2): rstmaster low -> all outputs at reset values immediately; in_addr=0.
- Three host_rdy pulses, host_run=0, core_done=1 -> in_we high for 3 cycles each; in_addr ends at 3; load_full=0.
- IN_DEPTH=2, three pulses -> in_addr=2, load_full=1; third request produces no in_we.
- Full run, N_REC=4, NUM_CH=8:
  - core pulses core_done low then high four times, res_in = record index.
  - Expect out_we at out_addr 0, 8, 16, 24 with the matching res_out, then done_all=1.
- Five core_fetch edges in run -> rd_addr 8, 16, 24, 24, 24; a fetch edge coincident with WRITE still advances rd_addr.
- host_run dropped during WAIT_DONE -> IDLE next cycle; out_we stays 0; out_addr held.
